// File: rtl/memory_access_controller.sv
// ----------------------------------------------------------------------------
// memory_access_controller
//
// Sequences single read/write requests from the load/store path onto the
// asynchronous, level-sensitive Memory array. Each in-range access goes
// through a registered SETUP -> STROBE -> HOLD sequence, so address and write
// data are stable before a strobe rises, stay put while it is high, and are
// still unchanged on the edge that drops it. Addresses with the top bit set
// fall outside the array and are answered with an error response without
// touching the memory.
//
// Ports
//   clock            single clock, everything changes on its rising edge
//   reset            synchronous, active-high
//   req_valid        request present
//   req_ready        request can be accepted (IDLE and not in reset)
//   req_write        1 = write, 0 = read
//   req_address      word address, ADDRESS_WIDTH+1 bits (top bit = out of range)
//   req_write_data   write data, DATA_WIDTH+1 bits
//   resp_valid       one-cycle completion pulse
//   resp_error       qualifies resp_valid, 1 = address out of range
//   resp_read_data   last successfully read word, held between reads
//   mem_address      to memory address
//   mem_write        to memory write strobe
//   mem_read         to memory read strobe
//   mem_in           to memory data input
//   mem_out          from memory data output (high-Z while mem_read is low)
//
// ACCESS_CYCLES sets how long a strobe stays high; legal range 1..15.
// ----------------------------------------------------------------------------
module memory_access_controller #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDRESS_WIDTH:0] req_address,
    input  logic [DATA_WIDTH:0]    req_write_data,
    output logic                   resp_valid,
    output logic                   resp_error,
    output logic [DATA_WIDTH:0]    resp_read_data,
    output logic [ADDRESS_WIDTH:0] mem_address,
    output logic                   mem_write,
    output logic                   mem_read,
    output logic [DATA_WIDTH:0]    mem_in,
    input  logic [DATA_WIDTH:0]    mem_out
);

    // Sequencer states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    // The strobe counter starts here and the strobe ends when it reaches 0,
    // which gives exactly ACCESS_CYCLES strobe cycles.
    localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYCLES - 1);

    logic [1:0]             state_q,      state_d;
    logic [3:0]             count_q,      count_d;
    logic                   isWrite_q,    isWrite_d;
    logic                   respValid_q,  respValid_d;
    logic                   respError_q,  respError_d;
    logic [DATA_WIDTH:0]    readData_q,   readData_d;
    logic [ADDRESS_WIDTH:0] memAddress_q, memAddress_d;
    logic [DATA_WIDTH:0]    memIn_q,      memIn_d;
    logic                   memWrite_q,   memWrite_d;
    logic                   memRead_q,    memRead_d;

    logic acceptReq;
    logic outOfRange;

    // Ready is the only output not taken straight from a register: it must
    // fall in the same cycle reset rises so nothing is accepted under reset.
    assign req_ready  = (state_q == IDLE) && !reset;
    assign acceptReq  = req_valid && req_ready;
    assign outOfRange = req_address[ADDRESS_WIDTH];

    // Next-state logic. Strobes and the response pulse default to low so
    // they are only high in the state that owns them; address, data and the
    // read register default to holding.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        isWrite_d    = isWrite_q;
        respValid_d  = 1'b0;
        respError_d  = 1'b0;
        readData_d   = readData_q;
        memAddress_d = memAddress_q;
        memIn_d      = memIn_q;
        memWrite_d   = 1'b0;
        memRead_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (acceptReq) begin
                    isWrite_d = req_write;
                    if (outOfRange) begin
                        // Rejected requests never reach the memory pins.
                        state_d     = HOLD;
                        respValid_d = 1'b1;
                        respError_d = 1'b1;
                    end else begin
                        // The memory-side registers double as the request
                        // latch, so they are valid for the whole SETUP cycle.
                        state_d      = SETUP;
                        memAddress_d = req_address;
                        if (req_write) begin
                            memIn_d = req_write_data;
                        end
                    end
                end
            end

            SETUP: begin
                state_d    = STROBE;
                count_d    = STROBE_LAST;
                memWrite_d = isWrite_q;
                memRead_d  = !isWrite_q;
            end

            STROBE: begin
                if (count_q == 4'd0) begin
                    // mem_read is still high at this edge, so mem_out is
                    // driven and settled when it is captured.
                    state_d     = HOLD;
                    respValid_d = 1'b1;
                    if (!isWrite_q) begin
                        readData_d = mem_out;
                    end
                end else begin
                    count_d    = count_q - 4'd1;
                    memWrite_d = isWrite_q;
                    memRead_d  = !isWrite_q;
                end
            end

            HOLD: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset wins over everything, including a strobe in
    // progress, so an aborted access drops its strobe on the reset edge and
    // never produces a response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            isWrite_q    <= 1'b0;
            respValid_q  <= 1'b0;
            respError_q  <= 1'b0;
            readData_q   <= '0;
            memAddress_q <= '0;
            memIn_q      <= '0;
            memWrite_q   <= 1'b0;
            memRead_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            isWrite_q    <= isWrite_d;
            respValid_q  <= respValid_d;
            respError_q  <= respError_d;
            readData_q   <= readData_d;
            memAddress_q <= memAddress_d;
            memIn_q      <= memIn_d;
            memWrite_q   <= memWrite_d;
            memRead_q    <= memRead_d;
        end
    end

    assign resp_valid     = respValid_q;
    assign resp_error     = respError_q;
    assign resp_read_data = readData_q;
    assign mem_address    = memAddress_q;
    assign mem_in         = memIn_q;
    assign mem_write      = memWrite_q;
    assign mem_read       = memRead_q;

endmodule
